// File: rtl/dmem_responder_if.sv
// Load/store bus between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready slave that serves one load or store at a
// time after LATENCY wait states, with byte-lane writes and error reporting.

// One memory word. Powers up holding its own index and is never touched by reset.
module dmem_word #(
  parameter int IDX = 0
) (
  input  logic        clk,
  input  logic        we,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] data_q = 32'(IDX);
  logic [31:0] data_d;

  // Merge only the strobed byte lanes into the stored word
  always_comb begin
    data_d = data_q;
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) data_d[8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  // Word storage
  always_ff @(posedge clk) data_q <= data_d;

  assign rdata = data_q;
endmodule

module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [DEPTH-1:0][31:0] words;
  logic [29:0]            idx_full;
  logic [IW-1:0]          idx;
  logic                   addr_err;
  logic                   access;

  // Errors are judged on the latched address so late requester changes are ignored
  assign idx_full = addr_q[31:2];
  assign idx      = addr_q[IW+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00) || (idx_full >= 30'(DEPTH));
  assign access   = (state_q == BUSY) && (cnt_q == 4'd0);

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    dmem_word #(.IDX(w)) u_word (
      .clk   (clk),
      .we    (access && write_q && !addr_err && (idx == IW'(w))),
      .wstrb (wstrb_q),
      .wdata (wdata_q),
      .rdata (words[w])
    );
  end

  // Next-state and datapath for the IDLE -> BUSY -> RESP transaction sequence
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wstrb_d = bus.req_wstrb;
          cnt_d   = 4'(LATENCY);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Store commits through the word enables on this same edge
          err_d   = addr_err;
          rdata_d = (addr_err || write_q) ? 32'd0 : words[idx];
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rdata_d = 32'd0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and request-latch registers; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance share one
// requester driver (sel picks the target); results are checked against a
// word-array reference model with byte-lane merge.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;

  dmem_responder_if bus2();
  dmem_responder_if bus0();

  assign bus2.req_valid = req_valid & ~sel;
  assign bus0.req_valid = req_valid & sel;
  assign bus2.req_write = req_write;
  assign bus0.req_write = req_write;
  assign bus2.req_addr  = req_addr;
  assign bus0.req_addr  = req_addr;
  assign bus2.req_wdata = req_wdata;
  assign bus0.req_wdata = req_wdata;
  assign bus2.req_wstrb = req_wstrb;
  assign bus0.req_wstrb = req_wstrb;
  assign bus2.rsp_ready = rsp_ready;
  assign bus0.rsp_ready = rsp_ready;

  dmem_responder #(.DEPTH(128), .LATENCY(2)) dut  (.clk(clk), .rst(rst_n), .bus(bus2.slave));
  dmem_responder #(.DEPTH(128), .LATENCY(0)) dut0 (.clk(clk), .rst(rst_n), .bus(bus0.slave));

  logic        o_ready, o_valid, o_err;
  logic [31:0] o_rdata;
  assign o_ready = sel ? bus0.req_ready : bus2.req_ready;
  assign o_valid = sel ? bus0.rsp_valid : bus2.rsp_valid;
  assign o_rdata = sel ? bus0.rsp_rdata : bus2.rsp_rdata;
  assign o_err   = sel ? bus0.rsp_err   : bus2.rsp_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m2 [128];
  logic [31:0] m0 [128];

  // Reference: word array, errors leave memory alone, loads return the word
  task automatic model(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] st, output logic [31:0] rd, output logic er);
    int i;
    logic [31:0] cur;
    i  = int'(a >> 2);
    er = (a % 4 != 0) || (i >= 128);
    rd = 32'd0;
    if (!er) begin
      cur = s ? m0[i] : m2[i];
      if (w) begin
        for (int b = 0; b < 4; b++) if (st[b]) cur[8*b +: 8] = d[8*b +: 8];
        if (s) m0[i] = cur; else m2[i] = cur;
      end else begin
        rd = cur;
      end
    end
  endtask

  // Drive one request, scramble the inputs after acceptance, and wait for rsp_valid.
  // lat = posedges from the accept edge to the first cycle with rsp_valid, -1 on timeout.
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                       output int lat, output logic [31:0] rd, output logic er);
    logic rdy;
    int n;
    lat = -1; rd = 32'd0; er = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = st;
    n = 0;
    do begin
      rdy = o_ready;
      @(posedge clk);
      n++;
    end while (!rdy && n < 50);
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_wstrb = 4'($urandom);
    if (!rdy) return;
    n = 0;
    while (!o_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (o_valid) begin
      lat = n; rd = o_rdata; er = o_err;
    end
  endtask

  task automatic complete(input int hold);
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if (bus2.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus2.req_ready); end
    n_tests++; if (bus2.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus2.rsp_valid); end
    n_tests++; if (bus2.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", bus2.rsp_rdata); end
    n_tests++; if (bus2.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", bus2.rsp_err); end
    n_tests++; if (bus0.req_ready !== 1'b1 || bus0.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_lat0: got ready=%b valid=%b expected 1/0", bus0.req_ready, bus0.rsp_valid); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_basic();
    int lat; logic [31:0] rd, erd; logic er, eer;
    sel = 1'b0;
    model(1'b0, 1'b0, 32'h10, 32'd0, 4'h0, erd, eer);
    issue(1'b0, 32'h10, 32'd0, 4'h0, lat, rd, er);
    complete(0);
    n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL load_latency: got %0d expected 3", lat); end
    n_tests++; if (rd !== erd) begin n_fail++; $display("FAIL load_rdata: got %h expected %h", rd, erd); end
    n_tests++; if (er !== eer) begin n_fail++; $display("FAIL load_err: got %b expected %b", er, eer); end
  endtask

  task automatic test_strobe_write();
    int lat; logic [31:0] rd, erd; logic er, eer;
    model(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 4'b0011, erd, eer);
    issue(1'b1, 32'h20, 32'hDEADBEEF, 4'b0011, lat, rd, er);
    complete(0);
    n_tests++; if (rd !== 32'd0 || er !== 1'b0) begin n_fail++; $display("FAIL store_rsp: got rdata=%h err=%b expected 0/0", rd, er); end
    model(1'b0, 1'b0, 32'h20, 32'd0, 4'h0, erd, eer);
    issue(1'b0, 32'h20, 32'd0, 4'h0, lat, rd, er);
    complete(0);
    n_tests++; if (rd !== erd) begin n_fail++; $display("FAIL strobe_readback: got %h expected %h", rd, erd); end
  endtask

  task automatic test_stall();
    int lat, n; logic [31:0] rd, erd, erd2; logic er, eer;
    model(1'b0, 1'b0, 32'h08, 32'd0, 4'h0, erd, eer);
    model(1'b0, 1'b0, 32'h0C, 32'd0, 4'h0, erd2, eer);
    rsp_ready = 1'b0;
    issue(1'b0, 32'h08, 32'd0, 4'h0, lat, rd, er);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (o_valid !== 1'b1 || o_rdata !== erd || o_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got valid=%b rdata=%h ready=%b expected 1/%h/0", i, o_valid, o_rdata, o_ready, erd);
      end
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0C; req_wstrb = 4'h0;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_fail++; $display("FAIL stall_handshake: got valid=%b ready=%b expected 0/1", o_valid, o_ready); end
    @(negedge clk);
    n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL stall_next_accept: got ready=%b expected 0", o_ready); end
    req_valid = 1'b0; req_addr = $urandom;
    n = 0;
    while (!o_valid && n < 50) begin @(negedge clk); n++; end
    n_tests++; if (n !== 3 || o_rdata !== erd2) begin n_fail++; $display("FAIL stall_second: got lat=%0d rdata=%h expected 3/%h", n, o_rdata, erd2); end
    complete(0);
  endtask

  task automatic test_error();
    int lat; logic [31:0] rd, erd; logic er, eer;
    model(1'b0, 1'b1, 32'h22, 32'h12345678, 4'hF, erd, eer);
    issue(1'b1, 32'h22, 32'h12345678, 4'hF, lat, rd, er);
    complete(0);
    n_tests++; if (er !== 1'b1 || rd !== 32'd0 || lat !== 3) begin n_fail++; $display("FAIL misaligned_store: got err=%b rdata=%h lat=%0d expected 1/0/3", er, rd, lat); end
    model(1'b0, 1'b0, 32'h20, 32'd0, 4'h0, erd, eer);
    issue(1'b0, 32'h20, 32'd0, 4'h0, lat, rd, er);
    complete(0);
    n_tests++; if (rd !== erd || er !== 1'b0) begin n_fail++; $display("FAIL misaligned_unchanged: got %h expected %h", rd, erd); end
  endtask

  task automatic test_oob_and_lat0();
    int lat; logic [31:0] rd, erd; logic er, eer;
    issue(1'b0, 32'h200, 32'd0, 4'h0, lat, rd, er);
    complete(0);
    n_tests++; if (er !== 1'b1 || rd !== 32'd0 || lat !== 3) begin n_fail++; $display("FAIL oob_load: got err=%b rdata=%h lat=%0d expected 1/0/3", er, rd, lat); end
    sel = 1'b1;
    model(1'b1, 1'b0, 32'h14, 32'd0, 4'h0, erd, eer);
    issue(1'b0, 32'h14, 32'd0, 4'h0, lat, rd, er);
    complete(0);
    n_tests++; if (lat !== 1 || rd !== erd || er !== eer) begin n_fail++; $display("FAIL lat0_load: got lat=%0d rdata=%h err=%b expected 1/%h/%b", lat, rd, er, erd, eer); end
    sel = 1'b0;
  endtask

  task automatic test_reset_busy();
    int lat, n; logic rdy; logic [31:0] rd, erd; logic er, eer;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h55; req_wstrb = 4'hF;
    n = 0;
    do begin rdy = o_ready; @(posedge clk); n++; end while (!rdy && n < 50);
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL busy_before_reset: got ready=%b expected 0", o_ready); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_rdata !== 32'd0 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got ready=%b valid=%b rdata=%h err=%b expected 1/0/0/0", o_ready, o_valid, o_rdata, o_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model(1'b0, 1'b0, 32'h30, 32'd0, 4'h0, erd, eer);
    issue(1'b0, 32'h30, 32'd0, 4'h0, lat, rd, er);
    complete(0);
    n_tests++; if (rd !== erd || lat !== 3) begin n_fail++; $display("FAIL reset_drops_store: got rdata=%h lat=%0d expected %h/3", rd, lat, erd); end
  endtask

  task automatic test_random();
    int lat, hold, idx, exp_lat; logic w; logic [31:0] a, d, rd, erd; logic [3:0] st; logic er, eer;
    for (int t = 0; t < 300; t++) begin
      sel  = 1'($urandom);
      w    = 1'($urandom);
      idx  = ($urandom % 10 == 0) ? int'($urandom_range(120, 140)) : int'($urandom_range(0, 15));
      a    = 32'(idx) << 2;
      if ($urandom % 8 == 0) a = a + 32'($urandom_range(1, 3));
      d    = $urandom;
      st   = 4'($urandom);
      hold = int'($urandom_range(0, 2));
      exp_lat = sel ? 1 : 3;
      model(sel, w, a, d, st, erd, eer);
      rsp_ready = (hold == 0);
      issue(w, a, d, st, lat, rd, er);
      complete(hold);
      n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rand_lat[%0d]: got %0d expected %0d", t, lat, exp_lat); end
      n_tests++; if (rd !== erd) begin n_fail++; $display("FAIL rand_rdata[%0d] addr=%h: got %h expected %h", t, a, rd, erd); end
      n_tests++; if (er !== eer) begin n_fail++; $display("FAIL rand_err[%0d] addr=%h: got %b expected %b", t, a, er, eer); end
    end
    sel = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      m2[i] = 32'(i);
      m0[i] = 32'(i);
    end
    test_reset();
    test_load_basic();
    test_strobe_write();
    test_stall();
    test_error();
    test_oob_and_lat0();
    test_reset_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
